// File: rtl/csa_pkg.sv
// Shared constants and helpers for the pipelined carry-skip adder/subtractor.
package csa_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Subtraction is a + ~b + 1, so the stage-0 carry-in is forced high in SUB.
  function automatic logic stage0_cin(input logic op, input logic cin);
    return (op == OP_SUB) ? 1'b1 : cin;
  endfunction

endpackage

// File: rtl/csa_block.sv
// Combinational BLK_W-bit ripple block with a carry-skip bypass mux.
module csa_block #(
  parameter int BLK_W = 2
) (
  input  logic [BLK_W-1:0] a,
  input  logic [BLK_W-1:0] b,
  input  logic             cin,
  output logic [BLK_W-1:0] sum,
  output logic             cout,
  output logic             ctop
);

  genvar gi;

  logic [BLK_W:0]   rc;
  logic [BLK_W-1:0] p;
  logic             blk_p;

  assign rc[0] = cin;

  for (gi = 0; gi < BLK_W; gi++) begin : rip
    assign p[gi]      = a[gi] ^ b[gi];
    assign sum[gi]    = p[gi] ^ rc[gi];
    assign rc[gi + 1] = (a[gi] & b[gi]) | (p[gi] & rc[gi]);
  end

  // When every bit propagates, the incoming carry bypasses the ripple chain.
  assign blk_p = &p;
  assign cout  = blk_p ? cin : rc[BLK_W];
  assign ctop  = rc[BLK_W-1];

endmodule

// File: rtl/pipelined_carryskip_adder.sv
// Pipelined carry-skip adder/subtractor: one SEG_W segment resolved per stage,
// global stall under output backpressure.
module pipelined_carryskip_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4,
  parameter int BLK_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NSEG = WIDTH / SEG_W;
  localparam int NBLK = SEG_W / BLK_W;

  genvar gi, bi;

  logic stall;
  logic ovf_reg;

  for (gi = 0; gi < NSEG; gi++) begin : stg
    localparam int LO  = gi * SEG_W;
    localparam int HI  = LO + SEG_W;
    localparam int PW  = WIDTH - LO;
    localparam int PWO = WIDTH - HI;
    // Stage record layout: {pending b, pending a, carry, sum[HI-1:0]}
    localparam int DW  = 2 * PWO + HI + 1;

    logic [PW-1:0]    op_a;
    logic [PW-1:0]    op_b;
    logic             c_in;
    logic             v_in;
    logic [NBLK:0]    bc;
    logic [NBLK-1:0]  ctop;
    logic [SEG_W-1:0] seg_sum;
    logic             seg_ovf;
    logic             unused_ctop;
    logic [DW-1:0]    data_next;
    logic [DW-1:0]    data_reg;
    logic             valid_reg;

    if (gi == 0) begin : src
      assign op_a = in_a;
      assign op_b = (in_op == OP_SUB) ? ~in_b : in_b;
      assign c_in = stage0_cin(in_op, in_cin);
      assign v_in = in_valid;
    end else begin : src
      assign op_a = stg[gi-1].data_reg[LO + 1 +: PW];
      assign op_b = stg[gi-1].data_reg[LO + 1 + PW +: PW];
      assign c_in = stg[gi-1].data_reg[LO];
      assign v_in = stg[gi-1].valid_reg;
    end

    assign bc[0] = c_in;

    for (bi = 0; bi < NBLK; bi++) begin : blk
      csa_block #(.BLK_W(BLK_W)) u_blk (
        .a    (op_a[bi*BLK_W +: BLK_W]),
        .b    (op_b[bi*BLK_W +: BLK_W]),
        .cin  (bc[bi]),
        .sum  (seg_sum[bi*BLK_W +: BLK_W]),
        .cout (bc[bi+1]),
        .ctop (ctop[bi])
      );
    end

    // Only the final stage's segment MSB carries feed the overflow flag.
    assign seg_ovf     = ctop[NBLK-1] ^ bc[NBLK];
    assign unused_ctop = &{1'b0, ctop, seg_ovf};

    if (gi == 0 && PWO > 0) begin : pk
      assign data_next = {op_b[PW-1:SEG_W], op_a[PW-1:SEG_W], bc[NBLK], seg_sum};
    end else if (gi == 0) begin : pk
      assign data_next = {bc[NBLK], seg_sum};
    end else if (PWO > 0) begin : pk
      assign data_next = {op_b[PW-1:SEG_W], op_a[PW-1:SEG_W], bc[NBLK], seg_sum,
                          stg[gi-1].data_reg[LO-1:0]};
    end else begin : pk
      assign data_next = {bc[NBLK], seg_sum, stg[gi-1].data_reg[LO-1:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
      end else if (!stall) begin
        valid_reg <= v_in;
        data_reg  <= data_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (!stall) begin
      ovf_reg <= stg[NSEG-1].seg_ovf;
    end
  end

  assign out_valid = stg[NSEG-1].valid_reg;
  assign out_sum   = stg[NSEG-1].data_reg[WIDTH-1:0];
  assign out_cout  = stg[NSEG-1].data_reg[WIDTH];
  assign out_ovf   = ovf_reg;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

endmodule

// File: tb/tb_pipelined_carryskip_adder.sv
// Scoreboard bench: driver pushes model results, monitor pops on output transfer.
module tb_pipelined_carryskip_adder;

  localparam int W    = 16;
  localparam int SEG  = 4;
  localparam int BLK  = 2;
  localparam int NSEG = W / SEG;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_op = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  pipelined_carryskip_adder #(.WIDTH(W), .SEG_W(SEG), .BLK_W(BLK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   lat_chk = 1'b0;
  bit   rdone = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain unsigned/signed integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic op);
    exp_t   e;
    longint ua = a;
    longint ub = b;
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint ru, rs;
    if (op == 1'b0) begin
      ru     = ua + ub + cin;
      rs     = sa + sb + cin;
      e.cout = (ru >= (64'sd1 <<< W));
    end else begin
      ru     = ua - ub;
      rs     = sa - sb;
      e.cout = (ua >= ub);
    end
    e.sum = ru[W-1:0];
    e.ovf = (rs > ((64'sd1 <<< (W-1)) - 1)) || (rs < -(64'sd1 <<< (W-1)));
    e.acc = 0;
    return e;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic op);
    int   waitc = 0;
    exp_t e;
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_op = op; in_valid = 1'b1;
    #1;
    while (!in_ready && waitc < 200) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    e = model(a, b, cin, op);
    e.acc = cyc + 1;
    expq.push_back(e);
    $display("beat a=%h b=%h cin=%0d op=%0d -> exp sum=%h cout=%0d ovf=%0d",
             a, b, cin, op, e.sum, e.cout, e.ovf);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_left", expq.size(), 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '1;
      1: return '0;
      2: return {1'b0, {(W-1){1'b1}}};
      3: return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: checks handshake relation every cycle and results on transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        chk("in_ready", in_ready, !(out_valid && !out_ready));
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            e = expq.pop_front();
            chk("sum", out_sum, e.sum);
            chk("cout", out_cout, e.cout);
            chk("ovf", out_ovf, e.ovf);
            if (lat_chk) chk("latency", cyc - e.acc, NSEG - 1);
          end
        end
      end
    end
  end

  logic [W-1:0] da [6] = '{16'h0001, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
  logic [W-1:0] db [6] = '{16'h0001, 16'hFFFF, 16'h0000, 16'h0001, 16'h0007, 16'h0001};
  logic         dc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic         dop[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cout", out_cout, 0);
    chk("rst_out_ovf", out_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);

    // Directed corner cases, one at a time, with exact latency.
    lat_chk = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(da[i], db[i], dc[i], dop[i]);
      drain();
    end

    // Back-to-back stream with no backpressure.
    for (int i = 0; i < 40; i++) send(pick(), pick(), 1'($urandom), 1'($urandom));
    drain();

    // Eight-beat stream with a 3-cycle out_ready gap mid-stream.
    lat_chk = 1'b0;
    fork
      for (int i = 0; i < 8; i++) send(pick(), pick(), 1'($urandom), 1'($urandom));
      begin
        repeat (5) @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Random backpressure.
    rdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) send(pick(), pick(), 1'($urandom), 1'($urandom));
        rdone = 1'b1;
      end
      while (!rdone) begin
        @(negedge clk);
        out_ready = ($urandom_range(0, 3) != 0);
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with beats in flight and the output stalled.
    out_ready = 1'b0;
    for (int i = 0; i < NSEG; i++) send(pick(), pick(), 1'($urandom), 1'($urandom));
    @(negedge clk);
    #3;
    chk("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_sum", out_sum, 0);
    chk("async_rst_in_ready", in_ready, 1);
    expq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    lat_chk = 1'b1;
    send(16'h1234, 16'h4321, 1'b1, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
